// File: rtl/ex_stage.sv
// ex_stage: RV32I/RV32M execute stage sitting between the ID/EX and EX/MEM
// pipeline buffers. Single-cycle ALU ops are captured into EX/MEM on every
// falling clock edge. M ops run on an iterative 32-step shift-add / restoring
// unit and stall the front end through busy until the result is captured.
module ex_stage #(
  parameter int MDU_EN    = 1,
  parameter int MDU_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        MemRead_i,
  input  logic        MemtoReg_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] rs1Data_i,
  input  logic [31:0] rs2Data_i,
  input  logic [31:0] imm32_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [4:0]  rd_i,
  output logic        MemRead_o,
  output logic        MemtoReg_o,
  output logic        MemWrite_o,
  output logic        RegWrite_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] storeData_o,
  output logic [2:0]  func3_o,
  output logic [4:0]  rd_o,
  output logic        branchTaken_o,
  output logic        busy
);

  localparam int CW = $clog2(MDU_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MDU_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  // Magnitude of a value that is treated as two's complement only when s is set.
  function automatic logic [31:0] f_mag(input logic [31:0] x, input logic s);
    f_mag = (s && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Conditional two's-complement negation used for the final sign fix-up.
  function automatic logic [31:0] f_neg32(input logic [31:0] x, input logic n);
    f_neg32 = n ? (32'd0 - x) : x;
  endfunction

  mdu_state_t r_state;
  mdu_state_t w_state_nxt;
  logic [CW-1:0] r_count;

  // Iterative unit: r_hi is the running high product / partial remainder,
  // r_lo the multiplier being consumed / quotient being built, r_b the
  // operand magnitude (multiplicand or divisor).
  logic [31:0] r_hi, r_lo, r_b, r_a;
  logic [2:0]  r_mfunc3;
  logic        r_neg, r_neg_rem;

  // EX/MEM pipeline buffer
  logic        r_mem_read, r_mem_to_reg, r_mem_write, r_reg_write;
  logic [31:0] r_alu_result, r_store_data;
  logic [2:0]  r_func3;
  logic [4:0]  r_rd;
  logic        r_branch_taken;

  logic [31:0] w_a, w_b;
  logic [31:0] w_alu_res;
  logic        w_taken;
  logic        w_m_op_raw, w_m_op;
  logic        w_sign_a, w_sign_b;
  logic        w_busy;
  logic [32:0] w_mul_sum, w_div_sh, w_div_diff;
  logic [31:0] w_hi_nxt, w_lo_nxt;
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_m_res;

  logic        w_nx_mem_read, w_nx_mem_to_reg, w_nx_mem_write, w_nx_reg_write;
  logic [31:0] w_nx_alu_result, w_nx_store_data;
  logic [2:0]  w_nx_func3;
  logic [4:0]  w_nx_rd;
  logic        w_nx_branch_taken;

  assign w_a        = rs1Data_i;
  assign w_b        = ALUSrc_i ? imm32_i : rs2Data_i;
  assign w_m_op_raw = (ALUOp_i == 2'b10) && (func7_i == 7'b0000001);
  assign w_m_op     = w_m_op_raw && (MDU_EN != 0);

  // Single-cycle RV32I ALU and branch comparator.
  always_comb begin
    w_alu_res = 32'd0;
    w_taken   = 1'b0;
    case (ALUOp_i)
      2'b00: w_alu_res = w_a + w_b;
      2'b01: begin
        w_alu_res = w_a - w_b;
        case (func3_i)
          3'b000:  w_taken = (w_a == w_b);
          3'b001:  w_taken = (w_a != w_b);
          3'b100:  w_taken = ($signed(w_a) < $signed(w_b));
          3'b101:  w_taken = ($signed(w_a) >= $signed(w_b));
          3'b110:  w_taken = (w_a < w_b);
          3'b111:  w_taken = (w_a >= w_b);
          default: w_taken = 1'b0;
        endcase
      end
      2'b10, 2'b11: begin
        case (func3_i)
          3'b000: begin
            // I-type never subtracts: func7 there is just immediate bits.
            if ((ALUOp_i == 2'b10) && func7_i[5]) begin
              w_alu_res = w_a - w_b;
            end else begin
              w_alu_res = w_a + w_b;
            end
          end
          3'b001:  w_alu_res = w_a << w_b[4:0];
          3'b010:  w_alu_res = {31'd0, ($signed(w_a) < $signed(w_b))};
          3'b011:  w_alu_res = {31'd0, (w_a < w_b)};
          3'b100:  w_alu_res = w_a ^ w_b;
          3'b101: begin
            if (func7_i[5]) begin
              w_alu_res = 32'($signed(w_a) >>> w_b[4:0]);
            end else begin
              w_alu_res = w_a >> w_b[4:0];
            end
          end
          3'b110:  w_alu_res = w_a | w_b;
          3'b111:  w_alu_res = w_a & w_b;
          default: w_alu_res = 32'd0;
        endcase
      end
      default: w_alu_res = 32'd0;
    endcase
  end

  // Which M operands are signed: mulh/mulhsu/div/rem for A, mulh/div/rem for B.
  always_comb begin
    w_sign_a = 1'b0;
    w_sign_b = 1'b0;
    case (func3_i)
      3'b001:  begin w_sign_a = 1'b1; w_sign_b = 1'b1; end
      3'b010:  begin w_sign_a = 1'b1; w_sign_b = 1'b0; end
      3'b100:  begin w_sign_a = 1'b1; w_sign_b = 1'b1; end
      3'b110:  begin w_sign_a = 1'b1; w_sign_b = 1'b1; end
      default: begin w_sign_a = 1'b0; w_sign_b = 1'b0; end
    endcase
  end

  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_div_sh   = {r_hi, r_lo[31]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_mfunc3[2]) begin
      if (!w_div_diff[32]) begin
        w_hi_nxt = w_div_diff[31:0];
        w_lo_nxt = {r_lo[30:0], 1'b1};
      end else begin
        w_hi_nxt = w_div_sh[31:0];
        w_lo_nxt = {r_lo[30:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_mul_sum[32:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[31:1]};
    end
  end

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;

  // Final M result with sign fix-up and the divide-by-zero special case.
  // Signed overflow needs no special handling: |A|=2^31, |B|=1 and equal
  // signs already yield quotient 0x80000000 and remainder 0.
  always_comb begin
    w_m_res = 32'd0;
    case (r_mfunc3)
      3'b000:               w_m_res = w_prod_s[31:0];
      3'b001, 3'b010, 3'b011: w_m_res = w_prod_s[63:32];
      3'b100, 3'b101: begin
        if (r_b == 32'd0) begin
          w_m_res = 32'hFFFF_FFFF;
        end else begin
          w_m_res = f_neg32(r_lo, r_neg);
        end
      end
      3'b110, 3'b111: begin
        if (r_b == 32'd0) begin
          w_m_res = r_a;
        end else begin
          w_m_res = f_neg32(r_hi, r_neg_rem);
        end
      end
      default: w_m_res = 32'd0;
    endcase
  end

  // MDU next state and stall request; clear always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_m_op && !clear) begin
          w_state_nxt = S_RUN;
          w_busy      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy      = 1'b0;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_count == LAST_STEP) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  assign busy = w_busy && !rst;

  // MDU state register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // MDU operand latch, iteration datapath and step counter.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_b       <= 32'd0;
      r_a       <= 32'd0;
      r_mfunc3  <= 3'd0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_m_op) begin
            r_count   <= '0;
            r_hi      <= 32'd0;
            r_lo      <= f_mag(w_a, w_sign_a);
            r_b       <= f_mag(w_b, w_sign_b);
            r_a       <= w_a;
            r_mfunc3  <= func3_i;
            r_neg     <= (w_sign_a & w_a[31]) ^ (w_sign_b & w_b[31]);
            r_neg_rem <= w_sign_a & w_a[31];
          end
        end
        S_RUN: begin
          r_hi <= w_hi_nxt;
          r_lo <= w_lo_nxt;
          if (r_count == LAST_STEP) begin
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_DONE:  r_count <= '0;
        default: r_count <= '0;
      endcase
    end
  end

  // EX/MEM next value: bubble on clear, while an M op is loading/running,
  // or for an M op when no MDU is built; otherwise ALU or M result.
  always_comb begin
    w_nx_mem_read      = 1'b0;
    w_nx_mem_to_reg    = 1'b0;
    w_nx_mem_write     = 1'b0;
    w_nx_reg_write     = 1'b0;
    w_nx_alu_result    = 32'd0;
    w_nx_store_data    = 32'd0;
    w_nx_func3         = 3'd0;
    w_nx_rd            = 5'd0;
    w_nx_branch_taken  = 1'b0;
    if (clear) begin
      w_nx_reg_write = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_m_op_raw) begin
            w_nx_mem_read     = MemRead_i;
            w_nx_mem_to_reg   = MemtoReg_i;
            w_nx_mem_write    = MemWrite_i;
            w_nx_reg_write    = RegWrite_i;
            w_nx_alu_result   = w_alu_res;
            w_nx_store_data   = rs2Data_i;
            w_nx_func3        = func3_i;
            w_nx_rd           = rd_i;
            w_nx_branch_taken = w_taken;
          end else begin
            w_nx_reg_write = 1'b0;
          end
        end
        S_RUN: w_nx_reg_write = 1'b0;
        S_DONE: begin
          w_nx_mem_read   = MemRead_i;
          w_nx_mem_to_reg = MemtoReg_i;
          w_nx_mem_write  = MemWrite_i;
          w_nx_reg_write  = RegWrite_i;
          w_nx_alu_result = w_m_res;
          w_nx_store_data = rs2Data_i;
          w_nx_func3      = func3_i;
          w_nx_rd         = rd_i;
        end
        default: w_nx_reg_write = 1'b0;
      endcase
    end
  end

  // EX/MEM pipeline buffer register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_mem_read     <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_mem_write    <= 1'b0;
      r_reg_write    <= 1'b0;
      r_alu_result   <= 32'd0;
      r_store_data   <= 32'd0;
      r_func3        <= 3'd0;
      r_rd           <= 5'd0;
      r_branch_taken <= 1'b0;
    end else begin
      r_mem_read     <= w_nx_mem_read;
      r_mem_to_reg   <= w_nx_mem_to_reg;
      r_mem_write    <= w_nx_mem_write;
      r_reg_write    <= w_nx_reg_write;
      r_alu_result   <= w_nx_alu_result;
      r_store_data   <= w_nx_store_data;
      r_func3        <= w_nx_func3;
      r_rd           <= w_nx_rd;
      r_branch_taken <= w_nx_branch_taken;
    end
  end

  assign MemRead_o     = r_mem_read;
  assign MemtoReg_o    = r_mem_to_reg;
  assign MemWrite_o    = r_mem_write;
  assign RegWrite_o    = r_reg_write;
  assign ALUResult_o   = r_alu_result;
  assign storeData_o   = r_store_data;
  assign func3_o       = r_func3;
  assign rd_o          = r_rd;
  assign branchTaken_o = r_branch_taken;

endmodule
